// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction memory loader.
//   state_t     : loader FSM encoding (3 bits)
//   is_busy()   : true while a load is consuming stream bytes
package imem_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : drop any partial word and restart at byte 0
//   byte_valid    : byte_data is consumed this cycle
//   byte_data     : stream byte
//   word_valid_c  : combinational, high while the 4th byte of a word is consumed
//   word_c        : combinational, completed word {b3,b2,b1,b0} when word_valid_c
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] asm_q;

    // New byte enters at the top so the first byte ends up in the LSBs after four shifts.
    assign word_c       = {byte_data, asm_q[WORD_W-1:BYTE_W]};
    assign word_valid_c = byte_valid && (idx == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (clear) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (byte_valid) begin
            idx   <= idx + IDX_W'(1);
            asm_q <= word_c;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: consumes a length/data/checksum byte stream,
// writes packed words to the instruction memory and holds the CPU in reset until done.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : pulse to begin a new load (ignored while busy)
//   in_valid / in_data / in_ready : byte stream handshake
//   wr_en / wr_addr / wr_data     : instruction memory write port
//   cpu_hold  : keep CPU in reset (busy or failed load)
//   busy, done, error : load status (done/error sticky until next start)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  word_idx;
    logic [BYTE_W-1:0] xor_acc;

    logic              accept_c;
    logic              clear_c;
    logic              pack_valid_c;
    logic              last_word_c;
    logic              word_valid_c;
    logic [WORD_W-1:0] word_c;
    logic [CNT_W-1:0]  len_c;

    assign accept_c     = in_valid && in_ready;
    assign clear_c      = start && !is_busy(state);
    assign pack_valid_c = accept_c && (state == ST_DATA);
    // Full 16-bit count while LEN_HI is on the bus; low byte was captured on LEN_LO.
    assign len_c        = {in_data, word_cnt[BYTE_W-1:0]};
    assign last_word_c  = (word_idx == word_cnt - CNT_W'(1));

    imem_loader_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear_c),
        .byte_valid   (pack_valid_c),
        .byte_data    (in_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_LEN_LO;
            ST_LEN_LO:                if (accept_c) state_nxt = ST_LEN_HI;
            ST_LEN_HI: begin
                if (accept_c) begin
                    if (32'(len_c) > DEPTH)       state_nxt = ST_ERR;
                    else if (len_c == CNT_W'(0))  state_nxt = ST_CSUM;
                    else                          state_nxt = ST_DATA;
                end
            end
            ST_DATA:                  if (word_valid_c && last_word_c) state_nxt = ST_CSUM;
            ST_CSUM: begin
                if (accept_c) state_nxt = (in_data == xor_acc) ? ST_DONE : ST_ERR;
            end
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs (status decoded from the next state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            word_idx <= '0;
            xor_acc  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= ADDR_W'(BASE_ADDR);
            wr_data  <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= is_busy(state_nxt);
            busy     <= is_busy(state_nxt);
            cpu_hold <= is_busy(state_nxt) || (state_nxt == ST_ERR);
            done     <= (state_nxt == ST_DONE);
            error    <= (state_nxt == ST_ERR);
            wr_en    <= word_valid_c;

            if (clear_c) begin
                word_cnt <= '0;
                word_idx <= '0;
                xor_acc  <= '0;
            end else begin
                // Checksum covers every byte before CSUM, length bytes included.
                if (accept_c && (state != ST_CSUM)) xor_acc <= xor_acc ^ in_data;
                if (accept_c && (state == ST_LEN_LO)) word_cnt <= CNT_W'(in_data);
                if (accept_c && (state == ST_LEN_HI)) word_cnt <= len_c;
                if (word_valid_c) begin
                    word_idx <= word_idx + CNT_W'(1);
                    wr_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'({word_idx, 2'b00});
                    wr_data  <= word_c;
                end
            end
        end
    end

endmodule
